// File: rtl/sig_mul_seq.sv
// Sequential radix-2 shift-add multiplier for unpacked significands.
// One multiplier bit is consumed per clock; valid/ready handshakes on input and output.
module sig_mul_seq #(
  parameter int W = 53
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   fa,
  input  logic [W-1:0]   fb,
  input  logic           za,
  input  logic           zb,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] prod,
  output logic           prod_zero,
  output logic           busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [2*W-1:0] p;
  logic [W-1:0]   a;
  logic [CW-1:0]  cnt;
  logic           pz;
  logic [W:0]     sum;
  logic           accept;
  logic           last;

  // Handshake decode and the add step of the current iteration
  always_comb begin
    accept = in_valid && (state == IDLE);
    last   = (cnt == CW'(W - 1));
    sum    = {1'b0, p[2*W-1:W]};
    if (p[0]) begin
      sum = {1'b0, p[2*W-1:W]} + {1'b0, a};
    end else begin
      sum = {1'b0, p[2*W-1:W]};
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (za || zb) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: P holds {upper partial sum, remaining multiplier bits}; shifts right each RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p   <= {(2*W){1'b0}};
      a   <= {W{1'b0}};
      cnt <= {CW{1'b0}};
      pz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (za || zb) begin
              p  <= {(2*W){1'b0}};
              pz <= 1'b1;
            end else begin
              a   <= fa;
              p   <= {{W{1'b0}}, fb};
              cnt <= {CW{1'b0}};
              pz  <= 1'b0;
            end
          end
        end
        RUN: begin
          p   <= {sum, p[W-1:1]};
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          p <= p;
        end
        default: begin
          p <= p;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign prod      = p;
  assign prod_zero = pz;

endmodule

// File: tb/tb_sig_mul_seq.sv
// Directed-vector and random bench for sig_mul_seq (W=53): product, zero shortcut,
// latency, backpressure, reset abort and handshake behaviour.
module tb_sig_mul_seq;

  localparam int W = 53;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   fa;
  logic [W-1:0]   fb;
  logic           za;
  logic           zb;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] prod;
  logic           prod_zero;
  logic           busy;

  int errors = 0;
  int checks = 0;

  sig_mul_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fa        (fa),
    .fb        (fb),
    .za        (za),
    .zb        (zb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .prod_zero (prod_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           az;
    logic           bz;
    logic [2*W-1:0] ep;
    logic           epz;
    int             stall;
    bit             hold;
  } vec_t;

  vec_t vt[7];

  task automatic check(input bit ok, input string nm, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full transaction: accept, wait for result, optional stall, handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic az, input logic bz, input int gap,
                        input int stall, input bit hold,
                        input logic [2*W-1:0] ep, input logic epz);
    int cyc;
    int exp_cyc;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    check(in_ready && !busy && !out_valid, "idle_flags",
          {in_ready, busy, out_valid}, 3'b100);
    fa = a; fb = b; za = az; zb = bz; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Offer a different pair while busy; it must not be taken.
    fa = ~a; fb = ~b; za = 1'b0; zb = 1'b0; in_valid = hold;
    // RUN fills cycles 1..W after acceptance, DONE shows in cycle W+1.
    exp_cyc = (az || bz) ? 1 : W + 1;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      check(!in_ready && busy, "run_flags", {in_ready, busy}, 2'b01);
      @(negedge clk);
      cyc++;
    end
    check(cyc == exp_cyc, "latency", cyc, exp_cyc);
    check(prod == ep, "prod", prod, ep);
    check(prod_zero == epz, "prod_zero", prod_zero, epz);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check(prod == ep && prod_zero == epz, "stall_prod", prod, ep);
      check(out_valid && !in_ready && busy, "stall_flags",
            {out_valid, in_ready, busy}, 3'b101);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check(in_ready && !out_valid && !busy, "post_handshake",
          {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    logic [2*W-1:0] max_p;
    logic [63:0]    r1;
    logic [63:0]    r2;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic           raz;
    logic           rbz;
    logic [2*W-1:0] rp;
    bit             seen;

    max_p = {{52{1'b1}}, {53{1'b0}}, 1'b1};
    vt[0] = '{W'(1) << 52, W'(1) << 52, 1'b0, 1'b0, (2*W)'(1) << 104, 1'b0, 0, 1'b0};
    vt[1] = '{{W{1'b1}}, {W{1'b1}}, 1'b0, 1'b0, max_p, 1'b0, 0, 1'b0};
    vt[2] = '{W'(53'h0_1234_5678_9ABC), W'(53'h1F_FFFF_FFFF_FFFF), 1'b1, 1'b0,
              (2*W)'(0), 1'b1, 0, 1'b0};
    vt[3] = '{W'(1) << 52, W'(53'h1F_FFFF_FFFF_FFFF), 1'b0, 1'b1, (2*W)'(0), 1'b1, 2, 1'b0};
    vt[4] = '{W'(3) << 51, W'(5) << 50, 1'b0, 1'b0, (2*W)'(15) << 101, 1'b0, 10, 1'b1};
    vt[5] = '{W'(1), W'(1), 1'b0, 1'b0, (2*W)'(1), 1'b0, 1, 1'b0};
    vt[6] = '{W'(53'h1F_FFFF_FFFF_FFFF), W'(1) << 52, 1'b0, 1'b0,
              (2*W)'(53'h1F_FFFF_FFFF_FFFF) << 52, 1'b0, 0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fa = '0; fb = '0; za = 1'b0; zb = 1'b0;
    repeat (2) @(negedge clk);
    check({in_ready, out_valid, busy, prod_zero} == 4'b1000, "reset_flags",
          {in_ready, out_valid, busy, prod_zero}, 4'b1000);
    check(prod == '0, "reset_prod", prod, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].az, vt[i].bz, 1, vt[i].stall, vt[i].hold,
             vt[i].ep, vt[i].epz);
    end

    // Reset in the 20th RUN cycle must abort the operation asynchronously.
    @(negedge clk);
    fa = W'(1) << 52; fb = W'(3) << 51; za = 1'b0; zb = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    check(busy && !out_valid, "pre_abort", {busy, out_valid}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check({in_ready, out_valid, busy, prod_zero} == 4'b1000, "async_reset_flags",
          {in_ready, out_valid, busy, prod_zero}, 4'b1000);
    check(prod == '0, "async_reset_prod", prod, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check(!seen, "no_valid_after_abort", seen, 1'b0);
    run_op(W'(1) << 52, W'(1) << 52, 1'b0, 1'b0, 0, 0, 1'b0, (2*W)'(1) << 104, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      r1  = {$urandom(), $urandom()};
      r2  = {$urandom(), $urandom()};
      ra  = r1[W-1:0];
      rb  = r2[W-1:0];
      raz = ($urandom_range(7) == 0);
      rbz = ($urandom_range(7) == 0);
      rp  = (raz || rbz) ? (2*W)'(0) : ({{W{1'b0}}, ra} * {{W{1'b0}}, rb});
      run_op(ra, rb, raz, rbz, $urandom_range(2),
             ($urandom_range(3) == 0) ? $urandom_range(3) : 0,
             ($urandom_range(3) == 0), rp, raz || rbz);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
